// File: rtl/load_store_unit.sv
// load_store_unit
//   Byte/halfword/word load-store front end for a word-wide Memory block.
//   Sub-word stores use read-modify-write because Memory commits whole words.
//   Misaligned requests and size 2'b11 complete with resp_err and never touch Memory.
//
// Ports
//   Clk, Reset          clock and synchronous active-high reset
//   req_valid/req_ready request handshake; req_ready is high only in IDLE
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_signed          load extension (sign when 1, zero when 0)
//   req_addr/req_wdata  byte address and store data (sub-word data in the low bits)
//   resp_valid          one-cycle completion pulse
//   resp_rdata          load result (0 for stores and errors)
//   resp_err            misaligned or illegal size
//   mem_Address         Memory address (word-indexed when WORD_ADDR=1)
//   mem_writeData       Memory write data
//   mem_writeEnable     Memory write strobe
//   mem_MemData         Memory combinational read data for mem_Address
module load_store_unit #(
  parameter bit WORD_ADDR = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_Address,
  output logic [31:0] mem_writeData,
  output logic        mem_writeEnable,
  input  logic [31:0] mem_MemData
);

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  // Latched request. Only the byte offset of the address is kept: the word
  // address goes straight into mem_Address at accept. Store data is kept
  // already replicated across lanes so the merge is a per-lane mux.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [31:0] wdata;
  } req_t;

  state_t state;
  req_t   rq;
  logic   weReg;

  logic                        reqErr;
  logic [31:0]                 wdataRep;
  logic [31:0]                 memAddrNext;
  logic [NUM_LANES-1:0]        byteEn;
  logic [NUM_LANES-1:0][7:0]   merged;
  logic [31:0]                 shifted;
  logic [31:0]                 loadData;

  assign req_ready = (state == IDLE);

  // A write in a reset cycle must never reach Memory.
  assign mem_writeEnable = weReg & ~Reset;

  always_comb begin
    reqErr = 1'b0;
    case (req_size)
      2'b01:   reqErr = req_addr[0];
      2'b10:   reqErr = (req_addr[1:0] != 2'b00);
      2'b11:   reqErr = 1'b1;
      default: reqErr = 1'b0;
    endcase
  end

  always_comb begin
    case (req_size)
      2'b00:   wdataRep = {4{req_wdata[7:0]}};
      2'b01:   wdataRep = {2{req_wdata[15:0]}};
      default: wdataRep = req_wdata;
    endcase
  end

  assign memAddrNext = WORD_ADDR ? {2'b00, req_addr[31:2]} : {req_addr[31:2], 2'b00};

  always_comb begin
    case (rq.size)
      2'b00:   byteEn = 4'b0001 << rq.off;
      2'b01:   byteEn = rq.off[1] ? 4'b1100 : 4'b0011;
      default: byteEn = 4'b1111;
    endcase
  end

  // Read-modify-write merge: target lanes from the store, rest from Memory.
  for (genvar k = 0; k < NUM_LANES; k++) begin : gLane
    assign merged[k] = byteEn[k] ? rq.wdata[8*k +: 8] : mem_MemData[8*k +: 8];
  end

  // Move the addressed lane down to bit 0, then extend. Halves are aligned
  // here, so a byte-granular shift selects them correctly.
  assign shifted = mem_MemData >> {rq.off, 3'b000};

  always_comb begin
    case (rq.size)
      2'b00:   loadData = {{24{rq.sgn & shifted[7]}},  shifted[7:0]};
      2'b01:   loadData = {{16{rq.sgn & shifted[15]}}, shifted[15:0]};
      default: loadData = mem_MemData;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      rq            <= '0;
      weReg         <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      mem_Address   <= '0;
      mem_writeData <= '0;
    end else begin
      case (state)
        IDLE: begin
          weReg      <= 1'b0;
          resp_valid <= 1'b0;
          if (req_valid) begin
            rq <= '{write: req_write, size: req_size, sgn: req_signed,
                    off: req_addr[1:0], wdata: wdataRep};
            if (reqErr) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && req_size == 2'b10) begin
              // Whole-word store needs no read.
              state         <= WR;
              mem_Address   <= memAddrNext;
              mem_writeData <= req_wdata;
              weReg         <= 1'b1;
            end else begin
              state       <= RD;
              mem_Address <= memAddrNext;
            end
          end
        end
        RD: begin
          // mem_MemData is the word at mem_Address; sample it at this edge.
          if (rq.write) begin
            state         <= WR;
            mem_writeData <= merged;
            weReg         <= 1'b1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= loadData;
          end
        end
        WR: begin
          state      <= RESP;
          weReg      <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
